// File: rtl/key_event_rx_pkg.sv
// Shared definitions for the key event receiver.
//   - event word layout: {repeat, press, key[KW-1:0]}
//   - EVT_PRESS / EVT_RELEASE encodings of the press field
//   - default debounce length for a 50 MHz clock (20 ms)
//   - idx_w(): width of a counter or index that must hold values 0..n-1 (minimum 1)
package key_event_rx_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_rx_key_debounce.sv
// key_debounce: two-flop synchroniser, persistence counter and stable-level flop for one key.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_n        raw asynchronous key, 0 = pressed
//   level        debounced level, 1 = pressed
//   flip         one-cycle strobe, asserted in the cycle the stable level is about to change
//   flip_press   type of that change (EVT_PRESS / EVT_RELEASE), valid with flip
module key_debounce
  import key_event_rx_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic flip,
  output logic flip_press
);

  localparam int CW = idx_w(DEBOUNCE_CYCLES);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable;
  logic          sample;
  logic [CW-1:0] cnt;

  assign sample     = ~sync_q2;
  assign flip       = (sample != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign flip_press = sample ? EVT_PRESS : EVT_RELEASE;
  assign level      = stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
      if (sample == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sample;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_rx.sv
// key_event_rx: debounces NKEYS push-buttons and delivers press/release events over a
// valid/ready stream through a small show-ahead FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_n[NKEYS]          raw keys, 0 = pressed
//   key_level[NKEYS]      debounced state, 1 = pressed
//   evt_valid/evt_ready   event stream handshake (pop on valid && ready)
//   evt_key/press/repeat  head event fields (all 0 while the FIFO is empty)
//   overflow / ovf_clr    sticky drop flag and its clear pulse (set wins)
// Build option: define KEY_REPEAT_EN to add the auto-repeat timer; without it evt_repeat is 0.
module key_event_rx
  import key_event_rx_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  localparam int KW = idx_w(NKEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KW-1:0]    evt_key,
  output logic             evt_press,
  output logic             evt_repeat,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int EW = KW + 2;
  localparam int AW = idx_w(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  logic [NKEYS-1:0] flip;
  logic [NKEYS-1:0] flip_press;
  logic [NKEYS-1:0] rep_req;
  logic [NKEYS-1:0] pend;
  logic [NKEYS-1:0] pend_press;
  logic [NKEYS-1:0] pend_rep;
  logic [KW-1:0]    sel_idx;
  logic             push;
  logic [EW-1:0]    push_data;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n[g]),
      .level      (key_level[g]),
      .flip       (flip[g]),
      .flip_press (flip_press[g])
    );
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = idx_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic          rep_active;
  logic [KW-1:0] rep_key;
  logic [RW-1:0] rep_cnt;
  logic          press_hit;
  logic [KW-1:0] press_idx;
  logic          rep_stop;
  logic          rep_fire;

  // Highest-index press wins when several flip together; it counts as the most recent.
  always_comb begin
    press_hit = 1'b0;
    press_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (flip[i] && (flip_press[i] == EVT_PRESS)) begin
        press_hit = 1'b1;
        press_idx = KW'(i);
      end
    end
  end

  assign rep_stop = flip[rep_key] && (flip_press[rep_key] == EVT_RELEASE);
  assign rep_fire = rep_active && !rep_stop && !press_hit && (rep_cnt == '0);

  always_comb begin
    rep_req = '0;
    if (rep_fire) rep_req[rep_key] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_active <= 1'b0;
      rep_key    <= '0;
      rep_cnt    <= '0;
    end else if (press_hit) begin
      rep_active <= 1'b1;
      rep_key    <= press_idx;
      rep_cnt    <= RW'(REPEAT_DELAY - 1);
    end else if (rep_active) begin
      if (rep_stop) begin
        rep_active <= 1'b0;
      end else if (rep_cnt == '0) begin
        rep_cnt <= RW'(REPEAT_PERIOD - 1);
      end else begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_req = '0;
`endif

  // Lowest pending index goes to the FIFO each cycle.
  always_comb begin
    sel_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = KW'(i);
    end
  end

  assign push      = |pend;
  assign push_data = {pend_rep[sel_idx], pend_press[sel_idx], sel_idx};

  // A new request takes priority over the drain of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_press <= '0;
      pend_rep   <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (flip[i] || rep_req[i]) begin
          pend[i]       <= 1'b1;
          pend_press[i] <= flip[i] ? flip_press[i] : EVT_PRESS;
          pend_rep[i]   <= !flip[i];
        end else if (push && (sel_idx == KW'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] head;

  assign full    = (count == OW'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop     = evt_valid && evt_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = mem[rd_ptr];

  // Fields are masked while empty so stale storage never shows on the outputs.
  assign evt_key    = evt_valid ? head[KW-1:0] : '0;
  assign evt_press  = evt_valid && head[KW];
  assign evt_repeat = evt_valid && head[KW+1];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule
